// File: rtl/param_lfsr.sv
// param_lfsr: BLOCK_SIZE+1 bit Fibonacci LFSR used as a keystream source.
// The feedback is the XOR of the maximal-length tap set for the register
// width and enters at the LSB as the register shifts left. An all-zero state
// (which the XOR network could never leave) reloads SEED on the next edge.
module param_lfsr #(
  parameter int                  BLOCK_SIZE = 32,
  parameter logic [BLOCK_SIZE:0] SEED       = {{BLOCK_SIZE{1'b0}}, 1'b1}
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  output logic [BLOCK_SIZE:0]   Y
);

  localparam int N = BLOCK_SIZE + 1;

  // One-hot mask for tap position p (positions are numbered 1..N).
  function automatic logic [63:0] tap_bit(input int p);
    tap_bit = 64'd1 << (p - 1);
  endfunction

  // Maximal-length tap sets (XAPP052) for every width 3..64.
  function automatic logic [63:0] tap_mask(input int n);
    case (n)
      3:  tap_mask = tap_bit(3)  | tap_bit(2);
      4:  tap_mask = tap_bit(4)  | tap_bit(3);
      5:  tap_mask = tap_bit(5)  | tap_bit(3);
      6:  tap_mask = tap_bit(6)  | tap_bit(5);
      7:  tap_mask = tap_bit(7)  | tap_bit(6);
      8:  tap_mask = tap_bit(8)  | tap_bit(6)  | tap_bit(5)  | tap_bit(4);
      9:  tap_mask = tap_bit(9)  | tap_bit(5);
      10: tap_mask = tap_bit(10) | tap_bit(7);
      11: tap_mask = tap_bit(11) | tap_bit(9);
      12: tap_mask = tap_bit(12) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
      13: tap_mask = tap_bit(13) | tap_bit(4)  | tap_bit(3)  | tap_bit(1);
      14: tap_mask = tap_bit(14) | tap_bit(5)  | tap_bit(3)  | tap_bit(1);
      15: tap_mask = tap_bit(15) | tap_bit(14);
      16: tap_mask = tap_bit(16) | tap_bit(15) | tap_bit(13) | tap_bit(4);
      17: tap_mask = tap_bit(17) | tap_bit(14);
      18: tap_mask = tap_bit(18) | tap_bit(11);
      19: tap_mask = tap_bit(19) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
      20: tap_mask = tap_bit(20) | tap_bit(17);
      21: tap_mask = tap_bit(21) | tap_bit(19);
      22: tap_mask = tap_bit(22) | tap_bit(21);
      23: tap_mask = tap_bit(23) | tap_bit(18);
      24: tap_mask = tap_bit(24) | tap_bit(23) | tap_bit(22) | tap_bit(17);
      25: tap_mask = tap_bit(25) | tap_bit(22);
      26: tap_mask = tap_bit(26) | tap_bit(6)  | tap_bit(2)  | tap_bit(1);
      27: tap_mask = tap_bit(27) | tap_bit(5)  | tap_bit(2)  | tap_bit(1);
      28: tap_mask = tap_bit(28) | tap_bit(25);
      29: tap_mask = tap_bit(29) | tap_bit(27);
      30: tap_mask = tap_bit(30) | tap_bit(6)  | tap_bit(4)  | tap_bit(1);
      31: tap_mask = tap_bit(31) | tap_bit(28);
      32: tap_mask = tap_bit(32) | tap_bit(22) | tap_bit(2)  | tap_bit(1);
      33: tap_mask = tap_bit(33) | tap_bit(20);
      34: tap_mask = tap_bit(34) | tap_bit(27) | tap_bit(2)  | tap_bit(1);
      35: tap_mask = tap_bit(35) | tap_bit(33);
      36: tap_mask = tap_bit(36) | tap_bit(25);
      37: tap_mask = tap_bit(37) | tap_bit(5)  | tap_bit(4)  | tap_bit(3) | tap_bit(2) | tap_bit(1);
      38: tap_mask = tap_bit(38) | tap_bit(6)  | tap_bit(5)  | tap_bit(1);
      39: tap_mask = tap_bit(39) | tap_bit(35);
      40: tap_mask = tap_bit(40) | tap_bit(38) | tap_bit(21) | tap_bit(19);
      41: tap_mask = tap_bit(41) | tap_bit(38);
      42: tap_mask = tap_bit(42) | tap_bit(41) | tap_bit(20) | tap_bit(19);
      43: tap_mask = tap_bit(43) | tap_bit(42) | tap_bit(38) | tap_bit(37);
      44: tap_mask = tap_bit(44) | tap_bit(43) | tap_bit(18) | tap_bit(17);
      45: tap_mask = tap_bit(45) | tap_bit(44) | tap_bit(42) | tap_bit(41);
      46: tap_mask = tap_bit(46) | tap_bit(45) | tap_bit(26) | tap_bit(25);
      47: tap_mask = tap_bit(47) | tap_bit(42);
      48: tap_mask = tap_bit(48) | tap_bit(47) | tap_bit(21) | tap_bit(20);
      49: tap_mask = tap_bit(49) | tap_bit(40);
      50: tap_mask = tap_bit(50) | tap_bit(49) | tap_bit(24) | tap_bit(23);
      51: tap_mask = tap_bit(51) | tap_bit(50) | tap_bit(36) | tap_bit(35);
      52: tap_mask = tap_bit(52) | tap_bit(49);
      53: tap_mask = tap_bit(53) | tap_bit(52) | tap_bit(38) | tap_bit(37);
      54: tap_mask = tap_bit(54) | tap_bit(53) | tap_bit(18) | tap_bit(17);
      55: tap_mask = tap_bit(55) | tap_bit(31);
      56: tap_mask = tap_bit(56) | tap_bit(55) | tap_bit(35) | tap_bit(34);
      57: tap_mask = tap_bit(57) | tap_bit(50);
      58: tap_mask = tap_bit(58) | tap_bit(39);
      59: tap_mask = tap_bit(59) | tap_bit(58) | tap_bit(38) | tap_bit(37);
      60: tap_mask = tap_bit(60) | tap_bit(59);
      61: tap_mask = tap_bit(61) | tap_bit(60) | tap_bit(46) | tap_bit(45);
      62: tap_mask = tap_bit(62) | tap_bit(61) | tap_bit(6)  | tap_bit(5);
      63: tap_mask = tap_bit(63) | tap_bit(62);
      64: tap_mask = tap_bit(64) | tap_bit(63) | tap_bit(61) | tap_bit(60);
      default: tap_mask = '0;
    endcase
  endfunction

  localparam logic [63:0]  TAP_MASK_FULL = tap_mask(N);
  localparam logic [N-1:0] TAP_MASK      = TAP_MASK_FULL[N-1:0];

  // Refuse to elaborate an unsupported width or a seed that would lock up.
  if (BLOCK_SIZE < 2 || BLOCK_SIZE > 63) begin : g_bad_block_size
    $error("param_lfsr: BLOCK_SIZE=%0d is outside the legal range 2..63", BLOCK_SIZE);
  end
  if (SEED == '0) begin : g_bad_seed
    $error("param_lfsr: SEED must be non-zero");
  end

  logic [N-1:0] y_q;
  logic [N-1:0] y_d;
  logic         fb;

  // Next state: zero-lock recovery beats enable; otherwise step or hold.
  always_comb begin
    y_d = y_q;
    fb  = ^(y_q & TAP_MASK);
    if (y_q == '0) begin
      y_d = SEED;
    end else if (enable) begin
      y_d = {y_q[N-2:0], fb};
    end
  end

  // State register with synchronous active-low reset to SEED.
  always_ff @(posedge clk) begin
    if (!reset) begin
      y_q <= SEED;
    end else begin
      y_q <= y_d;
    end
  end

  assign Y = y_q;

endmodule

// File: tb/tb_param_lfsr.sv
// Testbench for param_lfsr: default-width instance driven by directed and
// random stimulus against a behavioural model, plus one instance per
// BLOCK_SIZE 2..15 free-running to measure the sequence period.
module tb_param_lfsr;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic en;
  logic cov_rst_n;
  logic [32:0] dut_y;
  logic [63:0] cov_y [2:15];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // ---------------- DUTs ----------------
  param_lfsr u_dut (
    .clk    (clk),
    .reset  (rst_n),
    .enable (en),
    .Y      (dut_y)
  );

  for (genvar g = 2; g <= 15; g++) begin : g_cov
    logic [g:0] y;
    param_lfsr #(.BLOCK_SIZE(g)) u_cov (
      .clk    (clk),
      .reset  (cov_rst_n),
      .enable (1'b1),
      .Y      (y)
    );
    assign cov_y[g] = 64'(y);
  end

  // ---------------- scoreboard bookkeeping ----------------
  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Shift left one place within n bits; the new LSB is the XOR of the bits
  // at the two 1-based tap positions.
  function automatic logic [63:0] model_step(input logic [63:0] s, input int n,
                                             input int ta, input int tb);
    logic [63:0] mask;
    logic        fb;
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    fb   = s[ta-1] ^ s[tb-1];
    return ((s << 1) | 64'(fb)) & mask;
  endfunction

  logic [63:0] m33;
  logic [63:0] m4;
  logic        m33_valid = 1'b0;
  logic        m4_valid  = 1'b0;

  // Models advance on the same edge the DUTs do, using the sampled inputs.
  always @(posedge clk) begin
    if (!rst_n)              m33 = 64'd1;
    else if (m33 == 64'd0)   m33 = 64'd1;
    else if (en)             m33 = model_step(m33, 33, 33, 20);
    if (!rst_n) m33_valid = 1'b1;

    if (!cov_rst_n)          m4 = 64'd1;
    else if (m4 == 64'd0)    m4 = 64'd1;
    else                     m4 = model_step(m4, 4, 4, 3);
    if (!cov_rst_n) m4_valid = 1'b1;
  end

  // Per-cycle compare of DUT outputs against the models, away from posedge.
  always @(negedge clk) begin
    if (m33_valid) chk("y33_vs_model", 64'(dut_y), m33);
    if (m4_valid)  chk("y4_vs_model", cov_y[3], m4);
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge: apply inputs, let one posedge pass, return at negedge.
  task automatic cyc(input logic r, input logic e);
    rst_n = r;
    en    = e;
    @(negedge clk);
  endtask

  task automatic lit(input string name, input logic [63:0] exp);
    chk({name, "_model"}, m33, exp);
    chk({name, "_dut"}, 64'(dut_y), exp);
  endtask

  // ---------------- period coverage for widths 3..16 ----------------
  logic cov_done = 1'b0;

  initial begin
    int          first_ret [2:15];
    logic        zero_seen [2:15];
    int          visits [16];
    logic [63:0] n4_lit [5];
    logic [63:0] seed_v;
    n4_lit = '{64'h1, 64'h2, 64'h4, 64'h9, 64'h3};
    for (int g = 2; g <= 15; g++) begin
      first_ret[g] = 0;
      zero_seen[g] = 1'b0;
    end
    for (int v = 0; v < 16; v++) visits[v] = 0;
    seed_v = 64'd1;

    cov_rst_n = 1'b0;
    @(negedge clk);
    cov_rst_n = 1'b1;
    chk("n4_step0_dut", cov_y[3], n4_lit[0]);
    chk("n4_step0_model", m4, n4_lit[0]);
    for (int s = 1; s <= 65535; s++) begin
      @(negedge clk);
      if (s <= 4) begin
        chk("n4_seq_dut", cov_y[3], n4_lit[s]);
        chk("n4_seq_model", m4, n4_lit[s]);
      end
      if (s <= 15) visits[cov_y[3][3:0]]++;
      for (int g = 2; g <= 15; g++) begin
        if (cov_y[g] == 64'd0) zero_seen[g] = 1'b1;
        if (first_ret[g] == 0 && cov_y[g] == seed_v) first_ret[g] = s;
      end
    end
    for (int g = 2; g <= 15; g++) begin
      chk($sformatf("period_n%0d", g + 1), 64'(first_ret[g]), (64'd1 << (g + 1)) - 64'd1);
      chk($sformatf("never_zero_n%0d", g + 1), 64'(zero_seen[g]), 64'd0);
    end
    begin
      int bad;
      bad = (visits[0] != 0) ? 1 : 0;
      for (int v = 1; v < 16; v++) if (visits[v] != 1) bad++;
      chk("n4_all_states_once", 64'(bad), 64'd0);
    end
    cov_done = 1'b1;
  end

  // ---------------- main directed + random sequence ----------------
  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    @(negedge clk);
    lit("reset_edge1", 64'h1);
    cyc(1'b0, 1'b1);
    lit("reset_edge2", 64'h1);

    // Pure shifting until the first tap bit reaches position 20.
    for (int k = 1; k <= 19; k++) begin
      cyc(1'b1, 1'b1);
      lit($sformatf("shift_k%0d", k), 64'd1 << k);
    end
    cyc(1'b1, 1'b1);
    lit("feedback_step20", 64'h0_0010_0001);
    cyc(1'b1, 1'b1);
    lit("feedback_step21", 64'h0_0020_0002);

    // Reset, 10 steps, hold 5 cycles, one more step, reset with enable high.
    cyc(1'b0, 1'b1);
    lit("rerun_reset", 64'h1);
    for (int k = 1; k <= 10; k++) cyc(1'b1, 1'b1);
    lit("step10", 64'h400);
    for (int k = 0; k < 5; k++) begin
      cyc(1'b1, 1'b0);
      lit("hold", 64'h400);
    end
    cyc(1'b1, 1'b1);
    lit("reenable", 64'h800);
    cyc(1'b0, 1'b1);
    lit("reset_over_enable", 64'h1);

    // Random enable with occasional reset; checked by the per-cycle compare.
    for (int k = 0; k < 400; k++) begin
      cyc(($urandom_range(0, 15) != 0) ? 1'b1 : 1'b0, $urandom_range(0, 1) != 0);
    end

    // Coverage run is a fixed-length loop; bound the wait anyway.
    for (int t = 0; t < 70000 && !cov_done; t++) @(negedge clk);
    if (!cov_done) chk("coverage_timeout", 64'd0, 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/param_lfsr.md
# param_lfsr

Parameterised maximal-length linear feedback shift register used by the encryption datapath as a pseudo-random keystream source. The register is BLOCK_SIZE+1 bits wide and advances one step per enabled clock using a fixed Fibonacci XOR feedback network. The tap set is chosen at elaboration from BLOCK_SIZE. The full register state is exposed on Y every cycle for the downstream cipher logic.

## Interface
- BLOCK_SIZE, default 32: register width is N = BLOCK_SIZE+1. Legal range 2..63, giving N = 3..64.
- SEED, default 1: reset and recovery value of the register. N bits wide; must be non-zero.
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- enable  input  1  step enable; the register advances one step on each clk edge where it is high.
- Y  output  N (BLOCK_SIZE+1, [BLOCK_SIZE:0])  current register state; registered output with no combinational path from the inputs.

## Operation
- Bit positions are numbered 1..N, where position k is Y[k-1].
- Feedback fb is the XOR of the register bits at the tap positions for N.
- Step: Y_next = {Y[N-2:0], fb}. The register shifts left by one and fb enters the LSB.
- Taps are the Xilinx XAPP052 maximal-length set for N, held in a case table covering every N in 3..64. Examples:
  - N=3: 3,2
  - N=4: 4,3
  - N=8: 8,6,5,4
  - N=16: 16,15,13,4
  - N=32: 32,22,2,1
  - N=33: 33,20 (the default width)
  - N=64: 64,63,61,60
- A non-zero state cycles with period 2^N − 1. The all-zero state never appears in normal operation.
- Zero-lock guard: if Y is ever all zero, the next clk edge loads SEED, regardless of enable.
- Priority per edge, highest first:
  1. reset low → Y = SEED.
  2. Y all zero → Y = SEED.
  3. enable high → step.
  4. Otherwise → hold.
- Elaboration fails with a clear error when:
  - BLOCK_SIZE is outside 2..63, or
  - SEED is zero.

## Timing
- Reset value: Y = SEED (0x0_0000_0001 for the defaults). It is visible after the first clk edge with reset low.
- Reset is synchronous. Deasserting reset between edges has no effect until the next edge.
- Reset asserted mid-run overrides enable on that edge. Y = SEED on the following cycle.
- Latency is one cycle: Y reflects a step on the edge where enable was sampled high.
- Enable held high steps the register every cycle. Enable low freezes Y indefinitely.
- Y is undefined before the first edge with reset low. The bench drives reset low before or at the first edge.

## Test plan
- Reset: hold reset low for 2 edges with enable=1 → Y = 0x0_0000_0001 on both cycles.
- Initial shifting: release reset, enable=1, defaults → after k steps (k ≤ 19) Y = 1<<k. After 19 steps Y = 0x0_0008_0000.
- First feedback (taps 33,20):
  - Step 20 → Y = 0x0_0010_0001.
  - Step 21 → Y = 0x0_0020_0002.
- Hold then reset:
  - Drop enable after step 10 (Y = 0x400) for 5 cycles → Y stays 0x400.
  - Re-enable for one cycle → Y = 0x800.
  - Assert reset with enable high → Y = 0x1 on the next cycle.
- Short period, BLOCK_SIZE=3 (N=4, taps 4,3), seed 1, enable always high:
  - Sequence is 0x1, 0x2, 0x4, 0x9, 0x3, …
  - Returns to 0x1 after exactly 15 steps; all 15 non-zero states appear once.
- Tap table coverage: for each BLOCK_SIZE in 2..15, run 2^N − 1 steps from SEED → state first returns to SEED at exactly that count and is never zero.
